// File: rtl/typed_value_pkg.sv
// Shared types and helpers for the typed-value serializer and the register stage it feeds.
package typed_value_pkg;

    localparam int KIND_W = 2;

    typedef enum logic [KIND_W-1:0] {
        KIND_BYTE,
        KIND_SHORTINT,
        KIND_INT,
        KIND_LONGINT
    } kind_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } serializer_state_t;

    function automatic logic [3:0] kind_bytes(kind_t kind);
        return 4'd1 << kind;
    endfunction

    // True when data is exactly the zero/sign extension of its low kind-sized bytes.
    function automatic logic ext_ok(logic [63:0] data, kind_t kind, logic is_signed);
        logic [63:0] ext;
        case (kind)
            KIND_BYTE:     ext = is_signed ? {{56{data[7]}},  data[7:0]}  : {56'd0, data[7:0]};
            KIND_SHORTINT: ext = is_signed ? {{48{data[15]}}, data[15:0]} : {48'd0, data[15:0]};
            KIND_INT:      ext = is_signed ? {{32{data[31]}}, data[31:0]} : {32'd0, data[31:0]};
            default:       ext = data;
        endcase
        return ext == data;
    endfunction

endpackage

// File: rtl/typed_value_serializer_if.sv
// Upstream typed-value bus plus downstream byte link of the serializer.
interface typed_value_serializer_if;

    // valid/ready: a transfer happens on a rising clock edge where both valid and ready are
    // high; the source holds valid and payload stable until then, ready never depends on valid.
    logic                              i_valid;
    logic                              o_ready;
    logic [typed_value_pkg::KIND_W-1:0] i_kind;
    logic                              i_signed;
    logic [63:0]                       i_data;
    logic                              o_valid;
    logic                              i_ready;
    logic [7:0]                        o_data;
    logic                              o_first;
    logic                              o_last;
    logic                              o_range_err;

    modport master (
        output i_valid, i_kind, i_signed, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_first, o_last, o_range_err
    );

    modport slave (
        input  i_valid, i_kind, i_signed, i_data, i_ready,
        output o_ready, o_valid, o_data, o_first, o_last, o_range_err
    );

endinterface

// File: rtl/typed_value_serializer.sv
// Serializes one 64-bit typed value into 1/2/4/8 bytes on an 8-bit valid/ready link,
// flagging values that are not a legal extension of their kind.
module typed_value_serializer
    import typed_value_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    typed_value_serializer_if.slave bus,
    output serializer_state_t     o_dbg_state
);

    serializer_state_t state_q, state_d;
    logic [63:0]       shift_q, shift_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              first_q, first_d;
    logic              err_q, err_d;

    kind_t             kind;
    logic [3:0]        n_bytes;
    logic              ready;

    assign kind        = kind_t'(bus.i_kind);
    assign n_bytes     = kind_bytes(kind);
    assign ready       = (state_q == ST_IDLE) && !i_rst;
    assign o_dbg_state = state_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        cnt_d           = cnt_q;
        first_d         = first_q;
        err_d           = err_q;
        bus.o_ready     = ready;
        bus.o_valid     = 1'b0;
        bus.o_data      = '0;
        bus.o_first     = 1'b0;
        bus.o_last      = 1'b0;
        bus.o_range_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid && ready) begin
                    state_d = ST_SEND;
                    // MSB-first left-justifies the kind so its top byte lands in [63:56].
                    shift_d = LSB_FIRST ? bus.i_data
                                        : (bus.i_data << (7'd64 - {n_bytes, 3'b000}));
                    cnt_d   = 3'(n_bytes - 4'd1);
                    first_d = 1'b1;
                    err_d   = !ext_ok(bus.i_data, kind, bus.i_signed);
                end
            end
            ST_SEND: begin
                bus.o_valid     = 1'b1;
                bus.o_data      = LSB_FIRST ? shift_q[7:0] : shift_q[63:56];
                bus.o_first     = first_q;
                bus.o_last      = (cnt_q == 3'd0);
                bus.o_range_err = err_q;
                if (bus.i_ready) begin
                    shift_d = LSB_FIRST ? (shift_q >> 8) : (shift_q << 8);
                    cnt_d   = cnt_q - 3'd1;
                    first_d = 1'b0;
                    if (cnt_q == 3'd0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_typed_value_serializer.sv
// Directed bench driving an LSB-first and an MSB-first serializer in lockstep from one stimulus.
module tb_typed_value_serializer;
    import typed_value_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [1:0]  kind;
    logic        sgn;
    logic [63:0] data;
    logic        rdy;

    int vectors = 0;
    int errors  = 0;
    int hs_cnt  = 0;
    int cyc     = 0;
    int accept_cyc = 0;

    logic [10:0] exp_l[$];
    logic [10:0] exp_m[$];

    serializer_state_t dbg_l, dbg_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typed_value_serializer_if if_l();
    typed_value_serializer_if if_m();

    assign if_l.i_valid  = valid;
    assign if_l.i_kind   = kind;
    assign if_l.i_signed = sgn;
    assign if_l.i_data   = data;
    assign if_l.i_ready  = rdy;
    assign if_m.i_valid  = valid;
    assign if_m.i_kind   = kind;
    assign if_m.i_signed = sgn;
    assign if_m.i_data   = data;
    assign if_m.i_ready  = rdy;

    typed_value_serializer #(.LSB_FIRST(1'b1)) u_lsb (
        .i_clk(clk), .i_rst(rst), .bus(if_l), .o_dbg_state(dbg_l)
    );
    typed_value_serializer #(.LSB_FIRST(1'b0)) u_msb (
        .i_clk(clk), .i_rst(rst), .bus(if_m), .o_dbg_state(dbg_m)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        vectors++;
        errors++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    // Scoreboard model: byte order, framing and range error from the raw value.
    task automatic push_expected(input logic [1:0] k, input logic s, input logic [63:0] d);
        int          n;
        logic [63:0] upper;
        logic [63:0] ones;
        logic        err;
        n = 1 << k;
        err = 1'b0;
        if (n < 8) begin
            upper = d >> (8 * n);
            ones  = {64{1'b1}} >> (8 * n);
            if (s && d[8*n-1]) err = (upper != ones);
            else               err = (upper != 64'd0);
        end
        for (int i = 0; i < n; i++) begin
            exp_l.push_back({i == 0, i == n - 1, err, d[8*i +: 8]});
            exp_m.push_back({i == 0, i == n - 1, err, d[8*(n-1-i) +: 8]});
        end
    endtask

    // Monitor: every downstream handshake is popped and compared.
    always @(negedge clk) begin
        if (if_l.o_valid && rdy) begin
            hs_cnt++;
            if (exp_l.size() == 0) begin
                vectors++;
                assert (exp_l.size() != 0) else begin
                    errors++;
                    $error("FAIL lsb_unexpected: observed byte %0h expected none", if_l.o_data);
                end
            end else begin
                check("lsb_byte", {if_l.o_first, if_l.o_last, if_l.o_range_err, if_l.o_data},
                      exp_l.pop_front());
            end
        end
        if (if_m.o_valid && rdy) begin
            if (exp_m.size() == 0) begin
                vectors++;
                assert (exp_m.size() != 0) else begin
                    errors++;
                    $error("FAIL msb_unexpected: observed byte %0h expected none", if_m.o_data);
                end
            end else begin
                check("msb_byte", {if_m.o_first, if_m.o_last, if_m.o_range_err, if_m.o_data},
                      exp_m.pop_front());
            end
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [1:0] k, input logic s, input logic [63:0] d, input bit hold);
        int waited = 0;
        valid = 1'b1;
        kind  = k;
        sgn   = s;
        data  = d;
        while (1) begin
            @(negedge clk);
            if (if_l.o_ready && if_m.o_ready) break;
            waited++;
            if (waited > 100) begin
                fail_now("accept_timeout");
                valid = 1'b0;
                return;
            end
        end
        push_expected(k, s, d);
        accept_cyc = cyc;
        @(posedge clk);
        #1;
        if (!hold) valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_l.size() != 0 || exp_m.size() != 0) begin
            @(posedge clk);
            waited++;
            if (waited > 200) begin
                fail_now("drain_timeout");
                exp_l.delete();
                exp_m.delete();
            end
        end
        #1;
    endtask

    task automatic wait_hs(input int target);
        int waited = 0;
        while (hs_cnt < target) begin
            @(posedge clk);
            waited++;
            if (waited > 200) begin
                fail_now("handshake_timeout");
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int base;
        logic [63:0] d;

        rst = 1'b1; valid = 1'b0; kind = 2'd0; sgn = 1'b0; data = '0; rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_l", if_l.o_ready, 1'b0);
        check("rst_ready_m", if_m.o_ready, 1'b0);
        check("rst_valid",   if_l.o_valid, 1'b0);
        check("rst_data",    if_l.o_data, 8'h00);
        check("rst_flags",   {if_l.o_first, if_l.o_last, if_l.o_range_err}, 3'b000);
        check("rst_state",   dbg_l, ST_IDLE);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", if_l.o_ready, 1'b1);
        @(posedge clk); #1;

        // Unsigned int, EF BE AD DE on the LSB-first link.
        send(2'd2, 1'b0, 64'h0000_0000_DEAD_BEEF, 1'b0);
        drain();
        check("ready_after_last", if_l.o_ready, 1'b1);
        check("valid_after_last", if_l.o_valid, 1'b0);

        send(2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        drain();
        send(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        drain();
        send(2'd1, 1'b1, 64'h0000_0000_0000_8000, 1'b0);
        drain();

        // Longint with a 3-cycle stall on byte 04 of the MSB-first link.
        base = hs_cnt;
        send(2'd3, 1'b0, 64'h0102_0304_0506_0708, 1'b0);
        wait_hs(base + 3);
        #1;
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_msb_data", if_m.o_data, 8'h04);
            check("stall_lsb_data", if_l.o_data, 8'h05);
            check("stall_flags", {if_m.o_valid, if_m.o_first, if_m.o_last, if_m.o_range_err}, 4'b1000);
        end
        @(posedge clk); #1;
        rdy = 1'b1;
        drain();

        // Four shortints with i_valid held high: one accept every 3 cycles.
        send(2'd1, 1'b0, 64'h0000_0000_0000_1234, 1'b1);
        prev = accept_cyc;
        for (int i = 0; i < 3; i++) begin
            d = {48'd0, 16'($urandom_range(0, 65535))};
            send(2'd1, 1'b0, d, i != 2);
            check("accept_gap", accept_cyc - prev, 3);
            prev = accept_cyc;
        end
        drain();

        // Reset while the second longint byte is on the link.
        base = hs_cnt;
        send(2'd3, 1'b1, {$urandom, $urandom}, 1'b0);
        wait_hs(base + 1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid_l", if_l.o_valid, 1'b0);
        check("midrst_valid_m", if_m.o_valid, 1'b0);
        check("midrst_ready",   if_l.o_ready, 1'b0);
        exp_l.delete();
        exp_m.delete();
        @(negedge clk);
        check("midrst_data", if_m.o_data, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_ready", if_l.o_ready, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("postrst_no_stale", {if_l.o_valid, if_m.o_valid}, 2'b00);
        end
        @(posedge clk); #1;

        // Random kinds, mixing legal extensions and garbage upper bits.
        for (int i = 0; i < 8; i++) begin
            logic [1:0] k;
            logic       s;
            k = 2'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1 && k != 2'd3) begin
                d = (d << (64 - 8 * (1 << k)));
                d = s ? 64'($signed(d) >>> (64 - 8 * (1 << k))) : (d >> (64 - 8 * (1 << k)));
            end
            send(k, s, d, 1'b0);
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
